// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration readback path.
// CFG_W_DEF is the default per-cell configuration word width.
package cfg_pkg;

  localparam int         CFG_W_DEF = 33;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CRC_POLY  = 8'h07;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    COUNT,
    DATA,
    CRC
  } rb_state_t;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (poly 0x07, init 0, no reflection, no final XOR).
// Exists only when CFG_READBACK_CRC_EN is defined.
`ifdef CFG_READBACK_CRC_EN
module crc8_serial
  import cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_bit,
  output logic [7:0] o_crc
);

  logic [7:0] r_crc;
  logic       w_fb;

  assign w_fb  = r_crc[7] ^ i_bit;
  assign o_crc = r_crc;

  // Shift in one message bit per enable; clear restarts the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= '0;
    end else if (i_clr) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= {r_crc[6:0], 1'b0} ^ (w_fb ? CRC_POLY : 8'h00);
    end
  end

endmodule
`endif

// File: rtl/cfg_readback.sv
// Snapshots every cell's config word and streams a framed bitstream.
// Optional CRC-8 trailer enabled by CFG_READBACK_CRC_EN.
module cfg_readback
  import cfg_pkg::*;
#(
  parameter int NUM_CELLS = 16,
  parameter int CFG_W     = CFG_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CELLS*CFG_W-1:0] cfg_bus,
  input  logic                       start,
  output logic                       sout,
  output logic                       sout_valid,
  input  logic                       sout_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int TOT = NUM_CELLS * CFG_W;
  localparam int IW  = $clog2(TOT);
  localparam int BW  =
    ($clog2(CFG_W) > 3) ? $clog2(CFG_W) : 3;

  localparam logic [7:0]    CNT_BYTE  = 8'(NUM_CELLS);
  localparam logic [BW-1:0] LAST_BIT  = BW'(CFG_W - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(7);
  localparam logic [7:0]    LAST_CELL = 8'(NUM_CELLS - 1);

  rb_state_t     r_state;
  rb_state_t     w_state_nx;
  logic [BW-1:0] r_bit;
  logic [BW-1:0] w_bit_nx;
  logic [7:0]    r_cell;
  logic [7:0]    w_cell_nx;
  logic          r_done;
  logic          w_done_nx;
  logic [TOT-1:0] r_shadow;

  logic          w_acc;
  logic          w_start;
  logic          w_byte_end;
  logic [2:0]    w_bsel;
  logic [IW-1:0] w_pos;

  assign sout_valid = (r_state != IDLE);
  assign busy       = (r_state != IDLE);
  assign done       = r_done;

  assign w_acc      = sout_valid & sout_ready;
  assign w_start    = start & (r_state == IDLE);
  assign w_byte_end = (r_bit == BYTE_LAST);
  assign w_bsel     = ~r_bit[2:0];
  assign w_pos      = IW'(32'(r_cell) * CFG_W
                    + (CFG_W - 1) - 32'(r_bit));

`ifdef CFG_READBACK_CRC_EN
  logic [7:0] w_crc;
  logic       w_crc_en;

  assign w_crc_en = w_acc & (r_state != CRC);

  crc8_serial u_crc (
    .clk   (clk),
    .rst_n (rst),
    .i_clr (w_start),
    .i_en  (w_crc_en),
    .i_bit (sout),
    .o_crc (w_crc)
  );
`endif

  // Select the current frame bit, MSB first within each field.
  always_comb begin
    sout = 1'b0;
    case (r_state)
      SYNC:    sout = SYNC_BYTE[w_bsel];
      COUNT:   sout = CNT_BYTE[w_bsel];
      DATA:    sout = r_shadow[w_pos];
`ifdef CFG_READBACK_CRC_EN
      CRC:     sout = w_crc[w_bsel];
`endif
      default: sout = 1'b0;
    endcase
  end

  // Frame sequencing; counters only advance on an accepted bit.
  always_comb begin
    w_state_nx = r_state;
    w_bit_nx   = r_bit;
    w_cell_nx  = r_cell;
    w_done_nx  = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) w_state_nx = SYNC;
      end
      SYNC: begin
        if (w_acc) begin
          w_bit_nx = w_byte_end ? '0 : r_bit + BW'(1);
          if (w_byte_end) w_state_nx = COUNT;
        end
      end
      COUNT: begin
        if (w_acc) begin
          w_bit_nx = w_byte_end ? '0 : r_bit + BW'(1);
          if (w_byte_end) w_state_nx = DATA;
        end
      end
      DATA: begin
        if (w_acc) begin
          if (r_bit == LAST_BIT) begin
            w_bit_nx = '0;
            if (r_cell == LAST_CELL) begin
              w_cell_nx = '0;
`ifdef CFG_READBACK_CRC_EN
              w_state_nx = CRC;
`else
              w_state_nx = IDLE;
              w_done_nx  = 1'b1;
`endif
            end else begin
              w_cell_nx = r_cell + 8'd1;
            end
          end else begin
            w_bit_nx = r_bit + BW'(1);
          end
        end
      end
`ifdef CFG_READBACK_CRC_EN
      CRC: begin
        if (w_acc) begin
          w_bit_nx = w_byte_end ? '0 : r_bit + BW'(1);
          if (w_byte_end) begin
            w_state_nx = IDLE;
            w_done_nx  = 1'b1;
          end
        end
      end
`endif
      default: w_state_nx = IDLE;
    endcase
  end

  // State, counters and done pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_bit   <= '0;
      r_cell  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_bit   <= w_bit_nx;
      r_cell  <= w_cell_nx;
      r_done  <= w_done_nx;
    end
  end

  // Shadow copy of the whole bus, taken when a frame starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shadow <= '0;
    end else if (w_start) begin
      r_shadow <= cfg_bus;
    end
  end

endmodule
